voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic note-to-voice scheduler in front of the 8-voice NCO channel manager.
- Accepts note-on/note-off events over a valid/ready handshake.
- Looks up each note's NCO divider in an external synchronous ROM.
- Assigns notes to voices (free voice first, else steals the oldest) and drives the per-voice divider words. A divider <= MIN_DIVIDER (8) silences a voice.

Parameters:
- NUM_VOICES, 8, number of voices managed; fixed index width 3.
- D_W, 16, divider word width.
- NOTE_W, 7, note number width (MIDI 0..127).
- AGE_W, 4, width of each saturating voice age counter.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- note_valid  in  1  event present
- note_ready  out  1  block can accept an event (high only in IDLE)
- note_on  in  1  1 = note-on, 0 = note-off
- note_num  in  NOTE_W  note number
- div_lut_addr  out  NOTE_W  divider ROM address, registered
- div_lut_data  in  D_W  divider ROM data, valid 1 cycle after address
- voice_divider  out  NUM_VOICES*D_W  flat divider bus; voice i at bits [i*D_W +: D_W]
- voice_active  out  NUM_VOICES  voice holds a note
- steal_pulse  out  1  one-cycle pulse when an active voice is stolen

Behaviour:
- Reset values:
  - voice_divider = 0, voice_active = 0, steal_pulse = 0, div_lut_addr = 0.
  - All ages = 0, FSM = IDLE, so note_ready = 1. Events are ignored while sys_rst is high.
  - Reset mid-operation aborts the event with no partial write.
- FSM: IDLE -> SCAN -> WRITE -> IDLE.
  - Accept edge E0 (note_valid & note_ready): latch note_on and note_num; div_lut_addr <= note_num; go to SCAN.
  - SCAN: edges E1..E8 examine voice 0..7 in order, one per cycle.
  - WRITE: edge E9 applies the result; the FSM is back in IDLE after E9.
  - note_ready is low from after E0 until after E9: 10 cycles per event, independent of event type.
- Note-on scan records, in priority order:
  1. Lowest-index active voice with the same note -> retrigger: divider rewritten, age reset.
  2. Else lowest-index inactive voice.
  3. Else the active voice with maximum age; ties go to the lowest index. This is a steal, and steal_pulse is asserted for the cycle after E9.
- Note-on write at E9:
  - Chosen voice: divider <= div_lut_data (sampled at E9, stable since E1), active <= 1, age <= 0.
  - Every other active voice: age increments, saturating at 2^AGE_W-1.
- Note-on with div_lut_data <= 8 is dropped: no voice, age or steal change, but the full 10-cycle timing is still used.
- Note-off:
  - The scan marks every active voice with a matching note.
  - At E9 each marked voice gets divider <= 0 and active <= 0; ages of other voices are unchanged.
  - No match means no state change.
- Ages of inactive voices are held at 0.
- Outputs are registered; voice_divider changes only at E9 or at reset.

Optional Feature:
- Macro VOICE_ALLOC_SUSTAIN_EN adds input sustain_pedal (1 bit) and a per-voice released flag.
- With the macro:
  - While sustain_pedal = 1, note-off sets released on matching voices instead of clearing them. Divider and active are kept.
  - Stealing prefers the oldest released voice over any unreleased voice.
  - A retriggered voice has released cleared.
  - On a sustain_pedal fall, sampled in IDLE, all released voices are cleared in one cycle. A fall during SCAN/WRITE is latched and applied on the first IDLE cycle. note_ready is low during that clear cycle.
- Without the macro: no port, no flags; note-off always clears immediately.

Decomposition:
- Package voice_pkg holds:
  - NUM_VOICES, D_W, NOTE_W, AGE_W.
  - MIN_DIVIDER = 8.
  - FSM state encoding (IDLE, SCAN, WRITE, SUS_CLR).
  - Voice index type, 3 bits.
- One sub-module, voice_age_tracker. It holds the NUM_VOICES saturating age counters, with inputs clear_idx/clear_en/inc_en and a flat age bus out. The scan and compare logic stays in voice_allocator.

Test Plan:
All tests use a bench ROM with divider = 1000 + note.
- Reset, then note-on 60 -> note_ready low for exactly 10 cycles; voice 0 divider = 1060, voice_active = 8'h01, no steal_pulse.
- Note-ons 60..67, then note-on 70 -> voice 0 (age 7, oldest) is stolen: divider = 1070, steal_pulse high for 1 cycle, voice 0 age = 0, others incremented.
- Voices 0..2 hold 60/61/62; note-off 61 -> voice 1 divider = 0 and inactive; next note-on 72 lands in voice 1.
- Note-on 64 while 64 is already in voice 3 -> retrigger of voice 3 only; voice_active unchanged; no new voice consumed.
- Bench ROM returns 5 for note 0; note-on 0 -> no voice changes; note_ready returns after 10 cycles.
- Assert sys_rst during SCAN of note-on 60 -> all dividers 0, note_ready 1 after release, no partial write.
- With VOICE_ALLOC_SUSTAIN_EN: pedal up->down, note-on 60, note-off 60 -> voice 0 keeps 1060; pedal falls -> divider 0 the cycle after the first IDLE sample.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared constants, types and helpers for the voice allocator.
// VOICE_ALLOC_SUSTAIN_EN (optional) enables the sustain-pedal path in the top level.
package voice_pkg;

    localparam int unsigned NUM_VOICES = 8;
    localparam int unsigned D_W        = 16;
    localparam int unsigned NOTE_W     = 7;
    localparam int unsigned AGE_W      = 4;
    localparam int unsigned IDX_W      = 3;

    // Dividers at or below this value silence a voice, so such notes are dropped.
    localparam logic [D_W-1:0] MIN_DIVIDER = 16'd8;

    typedef logic [IDX_W-1:0] voice_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StWrite,
        StSusClr
    } state_e;

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] age);
        return (age == '1) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between an event source (master) and the allocator (slave).
interface voice_allocator_if;
    import voice_pkg::*;

    logic              note_valid;
    logic              note_ready;
    logic              note_on;
    logic [NOTE_W-1:0] note_num;

    modport master (
        output note_valid,
        output note_on,
        output note_num,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_on,
        input  note_num,
        output note_ready
    );

endinterface

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters; inactive voices are held at zero.
module voice_age_tracker
    import voice_pkg::*;
(
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  voice_idx_t                  clear_idx,
    input  logic                        clear_en,
    input  logic                        inc_en,
    input  logic [NUM_VOICES-1:0]       active_mask,
    output logic [NUM_VOICES*AGE_W-1:0] age_flat
);

    logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!active_mask[i]) begin
                age_d[i] = '0;
            end else if (clear_en && (clear_idx == voice_idx_t'(i))) begin
                age_d[i] = '0;
            end else if (inc_en) begin
                age_d[i] = age_sat_inc(age_q[i]);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age_flat = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice scheduler: scans the 8 voices one per cycle, then writes once.
// Optional VOICE_ALLOC_SUSTAIN_EN adds a sustain_pedal input and per-voice released flags.
module voice_allocator
    import voice_pkg::*;
(
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    voice_allocator_if.slave          note_if,
`ifdef VOICE_ALLOC_SUSTAIN_EN
    input  logic                      sustain_pedal,
`endif
    output logic [NOTE_W-1:0]         div_lut_addr,
    input  logic [D_W-1:0]            div_lut_data,
    output logic [NUM_VOICES*D_W-1:0] voice_divider,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic                      steal_pulse
);

    state_e                           state_q, state_d;
    logic                             on_q, on_d;
    logic [NOTE_W-1:0]                num_q, num_d;
    logic [NOTE_W-1:0]                addr_q, addr_d;
    voice_idx_t                       scan_q, scan_d;
    logic                             match_found_q, match_found_d;
    voice_idx_t                       match_idx_q, match_idx_d;
    logic                             free_found_q, free_found_d;
    voice_idx_t                       free_idx_q, free_idx_d;
    logic                             best_found_q, best_found_d;
    voice_idx_t                       best_idx_q, best_idx_d;
    logic [AGE_W:0]                   best_key_q, best_key_d;
    logic [NUM_VOICES-1:0]            off_mask_q, off_mask_d;
    logic [NUM_VOICES-1:0][D_W-1:0]   div_q, div_d;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0]            active_q, active_d;
    logic                             steal_q, steal_d;

    logic [NUM_VOICES*AGE_W-1:0]      age_flat;
    logic [NUM_VOICES-1:0]            rel_vec;
    logic                             sus_req;
    logic                             ready;
    logic [AGE_W:0]                   cur_key;
    voice_idx_t                       chosen;
    logic                             steal_sel;
    logic                             clear_en, inc_en;

`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic [NUM_VOICES-1:0] rel_q, rel_d;
    logic                  pedal_q;
    logic                  pend_q, pend_d;
    logic                  fall;

    assign fall    = pedal_q & ~sustain_pedal;
    assign sus_req = pend_q | fall;
    assign rel_vec = rel_q;
`else
    assign sus_req = 1'b0;
    assign rel_vec = '0;
`endif

    // Released voices outrank unreleased ones; among equals the strictly older one wins.
    assign cur_key   = {rel_vec[scan_q], age_flat[scan_q*AGE_W +: AGE_W]};
    assign steal_sel = !match_found_q && !free_found_q;
    assign chosen    = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : best_idx_q);

    always_comb begin
        state_d       = state_q;
        on_d          = on_q;
        num_d         = num_q;
        addr_d        = addr_q;
        scan_d        = scan_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        best_found_d  = best_found_q;
        best_idx_d    = best_idx_q;
        best_key_d    = best_key_q;
        off_mask_d    = off_mask_q;
        div_d         = div_q;
        note_d        = note_q;
        active_d      = active_q;
        steal_d       = 1'b0;
        clear_en      = 1'b0;
        inc_en        = 1'b0;
        ready         = 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
        rel_d         = rel_q;
        pend_d        = pend_q;
        if (fall && (state_q != StIdle)) begin
            pend_d = 1'b1;
        end
`endif

        unique case (state_q)
            StIdle: begin
                ready = !sus_req;
                if (sus_req) begin
                    state_d = StSusClr;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                    pend_d  = 1'b0;
`endif
                end else if (note_if.note_valid) begin
                    on_d          = note_if.note_on;
                    num_d         = note_if.note_num;
                    addr_d        = note_if.note_num;
                    scan_d        = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    best_found_d  = 1'b0;
                    off_mask_d    = '0;
                    state_d       = StScan;
                end
            end

            StScan: begin
                if (active_q[scan_q]) begin
                    if (note_q[scan_q] == num_q) begin
                        off_mask_d[scan_q] = 1'b1;
                        if (!match_found_q) begin
                            match_found_d = 1'b1;
                            match_idx_d   = scan_q;
                        end
                    end
                    if (!best_found_q || (cur_key > best_key_q)) begin
                        best_found_d = 1'b1;
                        best_idx_d   = scan_q;
                        best_key_d   = cur_key;
                    end
                end else if (!free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_q;
                end
                scan_d = scan_q + 1'b1;
                if (scan_q == voice_idx_t'(NUM_VOICES - 1)) begin
                    state_d = StWrite;
                end
            end

            StWrite: begin
                if (on_q) begin
                    if (div_lut_data > MIN_DIVIDER) begin
                        div_d[chosen]    = div_lut_data;
                        note_d[chosen]   = num_q;
                        active_d[chosen] = 1'b1;
                        clear_en         = 1'b1;
                        inc_en           = 1'b1;
                        steal_d          = steal_sel;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        rel_d[chosen]    = 1'b0;
`endif
                    end
                end else begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (off_mask_q[i]) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                            if (sustain_pedal) begin
                                rel_d[i] = 1'b1;
                            end else begin
                                div_d[i]    = '0;
                                active_d[i] = 1'b0;
                                rel_d[i]    = 1'b0;
                            end
`else
                            div_d[i]    = '0;
                            active_d[i] = 1'b0;
`endif
                        end
                    end
                end
                state_d = StIdle;
            end

            StSusClr: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (rel_q[i]) begin
                        div_d[i]    = '0;
                        active_d[i] = 1'b0;
                        rel_d[i]    = 1'b0;
                    end
                end
`endif
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= StIdle;
            on_q          <= 1'b0;
            num_q         <= '0;
            addr_q        <= '0;
            scan_q        <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            best_found_q  <= 1'b0;
            best_idx_q    <= '0;
            best_key_q    <= '0;
            off_mask_q    <= '0;
            div_q         <= '0;
            note_q        <= '0;
            active_q      <= '0;
            steal_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            on_q          <= on_d;
            num_q         <= num_d;
            addr_q        <= addr_d;
            scan_q        <= scan_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            best_found_q  <= best_found_d;
            best_idx_q    <= best_idx_d;
            best_key_q    <= best_key_d;
            off_mask_q    <= off_mask_d;
            div_q         <= div_d;
            note_q        <= note_d;
            active_q      <= active_d;
            steal_q       <= steal_d;
        end
    end

`ifdef VOICE_ALLOC_SUSTAIN_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rel_q   <= '0;
            pedal_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            rel_q   <= rel_d;
            pedal_q <= sustain_pedal;
            pend_q  <= pend_d;
        end
    end
`endif

    voice_age_tracker u_age (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .clear_idx   (chosen),
        .clear_en    (clear_en),
        .inc_en      (inc_en),
        .active_mask (active_d),
        .age_flat    (age_flat)
    );

    assign note_if.note_ready = ready;
    assign div_lut_addr       = addr_q;
    assign voice_divider      = div_q;
    assign voice_active       = active_q;
    assign steal_pulse        = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator; the ROM model returns 1000 + note (5 for note 0).
module tb_voice_allocator;
    import voice_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NOTE_W-1:0]         lut_addr;
    logic [D_W-1:0]            lut_data = '0;
    logic [NUM_VOICES*D_W-1:0] vdiv_bus;
    logic [NUM_VOICES-1:0]     vact;
    logic                      steal;
    int                        checks   = 0;
    int                        failures = 0;
    int                        cyc;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic                      pedal = 1'b0;
`endif

    voice_allocator_if ifc ();

    voice_allocator dut (
        .sys_clk       (clk),
        .sys_rst       (rst),
        .note_if       (ifc.slave),
`ifdef VOICE_ALLOC_SUSTAIN_EN
        .sustain_pedal (pedal),
`endif
        .div_lut_addr  (lut_addr),
        .div_lut_data  (lut_data),
        .voice_divider (vdiv_bus),
        .voice_active  (vact),
        .steal_pulse   (steal)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        lut_data <= (lut_addr == '0) ? 16'd5 : 16'd1000 + 16'(lut_addr);
    end

    function automatic logic [31:0] vdiv(input int i);
        return 32'(vdiv_bus[i*D_W +: D_W]);
    endfunction

    function automatic logic [31:0] vage(input int i);
        return 32'(dut.u_age.age_flat[i*AGE_W +: AGE_W]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns the accept cycle plus every following cycle with note_ready low.
    task automatic send(input logic on, input logic [NOTE_W-1:0] num, output int cycles);
        @(negedge clk);
        ifc.note_valid = 1'b1;
        ifc.note_on    = on;
        ifc.note_num   = num;
        @(posedge clk);
        #1;
        ifc.note_valid = 1'b0;
        cycles = 1;
        while (cycles < 40) begin
            @(negedge clk);
            if (ifc.note_ready) break;
            cycles++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        ifc.note_valid = 1'b1;
        ifc.note_on    = 1'b1;
        ifc.note_num   = 7'd60;
        repeat (3) @(negedge clk);
        ifc.note_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_div", 32'(vdiv_bus != '0), 0);
        chk("rst_active", 32'(vact), 0);
        chk("rst_steal", 32'(steal), 0);
        chk("rst_addr", 32'(lut_addr), 0);
        chk("rst_ready", 32'(ifc.note_ready), 1);

        // First note lands in voice 0
        send(1'b1, 7'd60, cyc);
        chk("on60_cycles", cyc, 10);
        chk("on60_div0", vdiv(0), 1060);
        chk("on60_active", 32'(vact), 32'h01);
        chk("on60_steal", 32'(steal), 0);
        chk("on60_addr", 32'(lut_addr), 60);

        // Fill all voices, then steal the oldest
        for (int n = 61; n <= 67; n++) send(1'b1, 7'(n), cyc);
        chk("fill_active", 32'(vact), 32'hFF);
        chk("fill_age0", vage(0), 7);
        chk("fill_age7", vage(7), 0);
        send(1'b1, 7'd70, cyc);
        chk("steal70_div0", vdiv(0), 1070);
        chk("steal70_pulse", 32'(steal), 1);
        chk("steal70_age0", vage(0), 0);
        chk("steal70_age1", vage(1), 7);
        chk("steal70_age7", vage(7), 1);
        chk("steal70_div1", vdiv(1), 1061);
        @(negedge clk);
        chk("steal70_pulse_end", 32'(steal), 0);
        send(1'b1, 7'd71, cyc);
        chk("steal71_div1", vdiv(1), 1071);
        chk("steal71_pulse", 32'(steal), 1);

        // Note-off frees a voice that the next note-on reuses
        do_reset();
        send(1'b1, 7'd60, cyc);
        send(1'b1, 7'd61, cyc);
        send(1'b1, 7'd62, cyc);
        send(1'b0, 7'd61, cyc);
        chk("off61_cycles", cyc, 10);
        chk("off61_div1", vdiv(1), 0);
        chk("off61_active", 32'(vact), 32'h05);
        send(1'b1, 7'd72, cyc);
        chk("on72_div1", vdiv(1), 1072);
        chk("on72_active", 32'(vact), 32'h07);
        send(1'b0, 7'd99, cyc);
        chk("off99_active", 32'(vact), 32'h07);
        chk("off99_div2", vdiv(2), 1062);

        // Retrigger of an already-sounding note
        send(1'b1, 7'd64, cyc);
        send(1'b1, 7'd65, cyc);
        chk("pre_retrig_age3", vage(3), 1);
        send(1'b1, 7'd64, cyc);
        chk("retrig_active", 32'(vact), 32'h1F);
        chk("retrig_div3", vdiv(3), 1064);
        chk("retrig_div5", vdiv(5), 0);
        chk("retrig_age3", vage(3), 0);
        chk("retrig_age4", vage(4), 1);
        chk("retrig_steal", 32'(steal), 0);

        // Divider at or below the silence threshold is dropped
        send(1'b1, 7'd0, cyc);
        chk("drop_cycles", cyc, 10);
        chk("drop_active", 32'(vact), 32'h1F);
        chk("drop_div5", vdiv(5), 0);
        chk("drop_age4", vage(4), 1);
        chk("drop_steal", 32'(steal), 0);

        // Reset in the middle of a scan leaves nothing behind
        do_reset();
        @(negedge clk);
        ifc.note_valid = 1'b1;
        ifc.note_on    = 1'b1;
        ifc.note_num   = 7'd60;
        @(posedge clk);
        #1;
        ifc.note_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(ifc.note_ready), 1);
        chk("midrst_div0", vdiv(0), 0);
        repeat (12) @(negedge clk);
        chk("midrst_late_div0", vdiv(0), 0);
        chk("midrst_late_active", 32'(vact), 0);

`ifdef VOICE_ALLOC_SUSTAIN_EN
        @(negedge clk);
        pedal = 1'b1;
        @(negedge clk);
        send(1'b1, 7'd60, cyc);
        send(1'b0, 7'd60, cyc);
        chk("sus_hold_div0", vdiv(0), 1060);
        chk("sus_hold_active", 32'(vact), 32'h01);
        pedal = 1'b0;
        @(negedge clk);
        chk("sus_clr_ready", 32'(ifc.note_ready), 0);
        chk("sus_clr_pending_div0", vdiv(0), 1060);
        @(negedge clk);
        chk("sus_clr_div0", vdiv(0), 0);
        chk("sus_clr_active", 32'(vact), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
